// File: rtl/vscale_ext_int_ctrl.sv
// External interrupt controller on the vscale reg bus: latches level/edge sources
// into pending, masks with enable, drives ext_interrupts_o. Optional: VSCALE_EXT_INT_SYNC_EN.
module vscale_ext_int_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int ADDR_W  = 14
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic              reg_wen,
  input  logic [ADDR_W-1:0] reg_waddr,
  input  logic [31:0]       reg_wdata,
  input  logic              reg_ren,
  input  logic [ADDR_W-1:0] reg_raddr,
  output logic [31:0]       reg_rdata,
  output logic [7:0]        ext_interrupts_o
);

  localparam int WA_W = ADDR_W - 2;
  localparam logic [WA_W-1:0] WORD_EOI     = WA_W'(0);
  localparam logic [WA_W-1:0] WORD_PENDING = WA_W'(1);
  localparam logic [WA_W-1:0] WORD_ENABLE  = WA_W'(2);
  localparam logic [WA_W-1:0] WORD_EDGESEL = WA_W'(3);
  localparam logic [WA_W-1:0] WORD_SWSET   = WA_W'(4);

  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] edge_sel;
  logic [NUM_SRC-1:0] s;
  logic [NUM_SRC-1:0] s_d;
  logic [NUM_SRC-1:0] set_hw;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] swset;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] wdata_src;
  logic [WA_W-1:0]    waddr_word;
  logic [WA_W-1:0]    raddr_word;
  logic [4:0]         claim_id;
  logic [31:0]        rd_next;
  logic [7:0]         out_next;
  logic               wr_eoi;
  logic               wr_enable;
  logic               wr_edgesel;
  logic               wr_swset;

  assign waddr_word = reg_waddr[ADDR_W-1:2];
  assign raddr_word = reg_raddr[ADDR_W-1:2];
  assign wdata_src  = reg_wdata[NUM_SRC-1:0];

  // Byte-lane bits and data bits above NUM_SRC carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{reg_waddr[1:0], reg_raddr[1:0], reg_wdata};

`ifdef VSCALE_EXT_INT_SYNC_EN
  logic [NUM_SRC-1:0] sync_q1;
  logic [NUM_SRC-1:0] sync_q2;

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_src_i;
      sync_q2 <= sync_q1;
    end
  end

  assign s = sync_q2;
`else
  assign s = irq_src_i;
`endif

  assign wr_eoi     = reg_wen && (waddr_word == WORD_EOI);
  assign wr_enable  = reg_wen && (waddr_word == WORD_ENABLE);
  assign wr_edgesel = reg_wen && (waddr_word == WORD_EDGESEL);
  assign wr_swset   = reg_wen && (waddr_word == WORD_SWSET);

  assign clr    = wr_eoi   ? wdata_src : '0;
  assign swset  = wr_swset ? wdata_src : '0;
  assign set_hw = (edge_sel & s & ~s_d) | (~edge_sel & s);
  assign active = pending & enable;

  always_comb begin
    claim_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) claim_id = 5'(i + 1);
    end
  end

  always_comb begin
    rd_next = '0;
    case (raddr_word)
      WORD_EOI:     rd_next[4:0]         = claim_id;
      WORD_PENDING: rd_next[NUM_SRC-1:0] = pending;
      WORD_ENABLE:  rd_next[NUM_SRC-1:0] = enable;
      WORD_EDGESEL: rd_next[NUM_SRC-1:0] = edge_sel;
      default:      rd_next              = '0;
    endcase
  end

  always_comb begin
    out_next = '0;
    out_next[NUM_SRC-1:0] = active;
  end

  // Set terms are OR'd after the clear so an event arriving with a W1C is kept.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      pending          <= '0;
      enable           <= '0;
      edge_sel         <= '0;
      s_d              <= '0;
      reg_rdata        <= '0;
      ext_interrupts_o <= '0;
    end else begin
      s_d              <= s;
      pending          <= (pending & ~clr) | set_hw | swset;
      ext_interrupts_o <= out_next;
      if (wr_enable)  enable   <= wdata_src;
      if (wr_edgesel) edge_sel <= wdata_src;
      if (reg_ren)    reg_rdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_vscale_ext_int_ctrl.sv
// Directed bench for vscale_ext_int_ctrl: register map, level/edge capture,
// W1C vs set priority, enable masking and async reset.
module tb_vscale_ext_int_ctrl;

`ifdef VSCALE_EXT_INT_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        clk_i = 1'b0;
  logic        reset;
  logic [7:0]  irq_src_i;
  logic        reg_wen;
  logic [13:0] reg_waddr;
  logic [31:0] reg_wdata;
  logic        reg_ren;
  logic [13:0] reg_raddr;
  logic [31:0] reg_rdata;
  logic [7:0]  ext_interrupts_o;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] rd_val;

  always #5 clk_i = ~clk_i;

  vscale_ext_int_ctrl #(.NUM_SRC(8), .ADDR_W(14)) dut (
    .clk_i            (clk_i),
    .reset            (reset),
    .irq_src_i        (irq_src_i),
    .reg_wen          (reg_wen),
    .reg_waddr        (reg_waddr),
    .reg_wdata        (reg_wdata),
    .reg_ren          (reg_ren),
    .reg_raddr        (reg_raddr),
    .reg_rdata        (reg_rdata),
    .ext_interrupts_o (ext_interrupts_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    reg_wen   = 1'b1;
    reg_waddr = a;
    reg_wdata = d;
    tick();
    reg_wen   = 1'b0;
  endtask

  task automatic rd(input logic [13:0] a, output logic [31:0] d);
    reg_ren   = 1'b1;
    reg_raddr = a;
    tick();
    reg_ren   = 1'b0;
    d = reg_rdata;
  endtask

  initial begin
    reset = 1'b1;
    irq_src_i = '0;
    reg_wen = 1'b0;
    reg_waddr = '0;
    reg_wdata = '0;
    reg_ren = 1'b0;
    reg_raddr = '0;
    repeat (3) tick();
    chk("reset_out", {24'b0, ext_interrupts_o}, 32'h0);
    chk("reset_rdata", reg_rdata, 32'h0);
    reset = 1'b0;
    tick();

    rd(14'h000, rd_val); chk("rst_claim", rd_val, 32'h0);
    rd(14'h004, rd_val); chk("rst_pending", rd_val, 32'h0);
    rd(14'h008, rd_val); chk("rst_enable", rd_val, 32'h0);
    rd(14'h00C, rd_val); chk("rst_edgesel", rd_val, 32'h0);

    // level mode, bit 0
    wr(14'h008, 32'h01);
    rd(14'h008, rd_val); chk("enable_rb", rd_val, 32'h01);
    irq_src_i = 8'h01;
    repeat (LAT - 1) tick();
    chk("lvl_lat_early", {24'b0, ext_interrupts_o}, 32'h00);
    tick();
    chk("lvl_lat_out", {24'b0, ext_interrupts_o}, 32'h01);
    rd(14'h000, rd_val); chk("lvl_claim", rd_val, 32'h1);
    wr(14'h000, 32'h01);
    repeat (2) tick();
    chk("lvl_eoi_held", {24'b0, ext_interrupts_o}, 32'h01);
    irq_src_i = 8'h00;
    repeat (4) tick();
    chk("lvl_drop_kept", {24'b0, ext_interrupts_o}, 32'h01);
    wr(14'h000, 32'h01);
    tick();
    chk("lvl_eoi_out", {24'b0, ext_interrupts_o}, 32'h00);

    // edge mode, bits 0 and 1 together
    wr(14'h00C, 32'h03);
    wr(14'h008, 32'h03);
    irq_src_i = 8'h03;
    tick();
    irq_src_i = 8'h00;
    repeat (LAT + 2) tick();
    chk("edge_out3", {24'b0, ext_interrupts_o}, 32'h03);
    rd(14'h000, rd_val); chk("edge_claim1", rd_val, 32'h1);
    wr(14'h000, 32'h01);
    tick();
    chk("edge_out2", {24'b0, ext_interrupts_o}, 32'h02);
    rd(14'h000, rd_val); chk("edge_claim2", rd_val, 32'h2);
    wr(14'h000, 32'h02);
    tick();
    chk("edge_out0", {24'b0, ext_interrupts_o}, 32'h00);
    rd(14'h000, rd_val); chk("edge_claim0", rd_val, 32'h0);

    // rising edge on bit 2 on the same edge as its W1C
    wr(14'h00C, 32'h04);
    wr(14'h008, 32'h04);
    rd(14'h004, rd_val); chk("prio_pre", rd_val, 32'h00);
    irq_src_i = 8'h04;
    repeat (LAT - 2) tick();
    wr(14'h000, 32'h04);
    irq_src_i = 8'h00;
    rd(14'h004, rd_val); chk("prio_pending", rd_val, 32'h04);
    chk("prio_out", {24'b0, ext_interrupts_o}, 32'h04);
    repeat (LAT + 1) tick();
    wr(14'h000, 32'h04);
    rd(14'h004, rd_val); chk("prio_cleared", rd_val, 32'h00);

    // software set with masking
    wr(14'h008, 32'h00);
    wr(14'h010, 32'h80);
    rd(14'h004, rd_val); chk("swset_pending", rd_val, 32'h80);
    chk("swset_masked", {24'b0, ext_interrupts_o}, 32'h00);
    rd(14'h010, rd_val); chk("swset_rd0", rd_val, 32'h0);
    rd(14'h000, rd_val); chk("swset_claim_masked", rd_val, 32'h0);
    wr(14'h008, 32'h80);
    chk("en_same_edge", {24'b0, ext_interrupts_o}, 32'h00);
    tick();
    chk("en_next", {24'b0, ext_interrupts_o}, 32'h80);
    rd(14'h000, rd_val); chk("claim8", rd_val, 32'h8);
    rd(14'h100, rd_val); chk("unmapped_rd", rd_val, 32'h0);
    wr(14'h004, 32'h00);
    wr(14'h100, 32'hFF);
    rd(14'h004, rd_val); chk("ro_pending", rd_val, 32'h80);
    wr(14'h008, 32'h00);
    tick();
    chk("en_clear_out", {24'b0, ext_interrupts_o}, 32'h00);
    rd(14'h004, rd_val); chk("en_clear_kept", rd_val, 32'h80);

    // read and write of the same register in one cycle
    reg_ren = 1'b1; reg_raddr = 14'h008;
    wr(14'h008, 32'h5A);
    reg_ren = 1'b0;
    chk("rdwr_old", reg_rdata, 32'h00);
    rd(14'h008, rd_val); chk("rdwr_new", rd_val, 32'h5A);

    // async reset mid-run with everything pending
    wr(14'h00C, 32'hFF);
    wr(14'h008, 32'hFF);
    wr(14'h010, 32'hFF);
    tick();
    chk("all_out", {24'b0, ext_interrupts_o}, 32'hFF);
    rd(14'h004, rd_val); chk("all_pending", rd_val, 32'hFF);
    #2;
    reset = 1'b1;
    #1;
    chk("async_out", {24'b0, ext_interrupts_o}, 32'h00);
    chk("async_rdata", reg_rdata, 32'h0);
    repeat (3) tick();
    reset = 1'b0;
    repeat (LAT + 2) tick();
    rd(14'h004, rd_val); chk("post_rst_pending", rd_val, 32'h00);
    rd(14'h00C, rd_val); chk("post_rst_edgesel", rd_val, 32'h00);
    wr(14'h00C, 32'hFF);
    wr(14'h008, 32'hFF);
    repeat (3) tick();
    chk("post_rst_quiet", {24'b0, ext_interrupts_o}, 32'h00);
    irq_src_i = 8'h08;
    repeat (LAT) tick();
    chk("post_rst_edge", {24'b0, ext_interrupts_o}, 32'h08);
    rd(14'h000, rd_val); chk("post_rst_claim", rd_val, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
